// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin share of one pipelined 64/16 remainder divider with in-order result routing
module div_share_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DIV_LATENCY = 68
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [N_REQ-1:0]      REQ,
  input  logic [64*N_REQ-1:0]   REQ_DIVIDEND,
  input  logic [16*N_REQ-1:0]   REQ_DIVISOR,
  output logic [N_REQ-1:0]      GNT,
  output logic [N_REQ-1:0]      RSP_VALID,
  output logic [16*N_REQ-1:0]   RSP_REM,
  output logic [N_REQ-1:0]      RSP_DIVZERO,
  output logic [63:0]           DIV_DIVIDEND,
  output logic [15:0]           DIV_DIVISOR,
  output logic                  DIV_TVALID,
  input  logic                  DIV_TREADY,
  input  logic [15:0]           DIV_REM,
  input  logic                  DIV_DOUT_TVALID,
  output logic                  ERR_UNDERFLOW
);
  localparam int tw = $clog2(N_REQ);
  localparam int cw = $clog2(N_REQ + 1);
  localparam int dw = $clog2(DIV_LATENCY + 1);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t           state, state_nx;
  logic [N_REQ-1:0] busy, elig;
  logic [tw-1:0]    rr, pick, cand, head, zidx, wr_ptr, rd_ptr;
  logic [tw-1:0]    fifo [N_REQ];
  logic [cw-1:0]    count;
  logic [dw-1:0]    drain;
  logic [63:0]      cur_dvd;
  logic [15:0]      cur_dvs;
  logic             found, do_grant, nz, push, pop, zval;

  assign elig    = REQ & ~busy;
  assign cur_dvd = REQ_DIVIDEND[64*pick +: 64];
  assign cur_dvs = REQ_DIVISOR[16*pick +: 16];
  assign head    = fifo[rd_ptr];
  assign push    = do_grant & nz;
  assign pop     = DIV_DOUT_TVALID & (count != '0);

  // first eligible requester strictly after the last winner, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = tw'((int'(rr) + k) % N_REQ);
      if (!found && elig[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else     state <= state_nx;

  always_comb
    state_nx = (state == IDLE) ? ((do_grant && nz) ? ISSUE : IDLE)
                               : ((DIV_TREADY) ? IDLE : ISSUE);

  always_comb begin
    do_grant   = (state == IDLE) && found && (drain == '0);
    nz         = cur_dvs != '0;
    DIV_TVALID = state == ISSUE;
  end

  always_ff @(posedge CLK)
    if (push) fifo[wr_ptr] <= pick;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      GNT           <= '0;
      RSP_VALID     <= '0;
      RSP_REM       <= '0;
      RSP_DIVZERO   <= '0;
      DIV_DIVIDEND  <= '0;
      DIV_DIVISOR   <= '0;
      ERR_UNDERFLOW <= 1'b0;
      busy          <= '0;
      rr            <= tw'(N_REQ - 1);
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      drain         <= dw'(DIV_LATENCY);
      zval          <= 1'b0;
      zidx          <= '0;
    end else begin
      GNT         <= '0;
      RSP_VALID   <= '0;
      RSP_DIVZERO <= '0;
      zval        <= do_grant & ~nz;
      zidx        <= pick;
      count       <= count + cw'(push) - cw'(pop);
      if (drain != '0) drain <= drain - 1'b1;
      // zero-divisor results bypass the divider and answer one cycle after the grant
      if (zval) begin
        RSP_VALID[zidx]         <= 1'b1;
        RSP_DIVZERO[zidx]       <= 1'b1;
        RSP_REM[16*zidx +: 16]  <= '0;
        busy[zidx]              <= 1'b0;
      end
      if (pop) begin
        RSP_VALID[head]         <= 1'b1;
        RSP_REM[16*head +: 16]  <= DIV_REM;
        busy[head]              <= 1'b0;
        rd_ptr                  <= (rd_ptr == tw'(N_REQ - 1)) ? '0 : rd_ptr + 1'b1;
      end
      // strays during the post-reset drain belong to operations issued before reset
      if (DIV_DOUT_TVALID && count == '0 && drain == '0) ERR_UNDERFLOW <= 1'b1;
      if (do_grant) begin
        GNT[pick]  <= 1'b1;
        busy[pick] <= 1'b1;
        rr         <= pick;
      end
      if (push) begin
        DIV_DIVIDEND <= cur_dvd;
        DIV_DIVISOR  <= cur_dvs;
        wr_ptr       <= (wr_ptr == tw'(N_REQ - 1)) ? '0 : wr_ptr + 1'b1;
      end
    end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed checks of arbitration, stall, zero divisor, reset drain and underflow
module tb_div_share_arbiter;
  localparam int N = 3;
  localparam int L = 68;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  REQ = '0;
  logic [64*N-1:0] REQ_DIVIDEND = '0;
  logic [16*N-1:0] REQ_DIVISOR = '0;
  logic [N-1:0]  GNT, RSP_VALID, RSP_DIVZERO;
  logic [16*N-1:0] RSP_REM;
  logic [63:0]   DIV_DIVIDEND;
  logic [15:0]   DIV_DIVISOR, DIV_REM;
  logic          DIV_TVALID, DIV_DOUT_TVALID, ERR_UNDERFLOW;
  logic          DIV_TREADY = 1'b1;
  logic          inj = 1'b0;
  logic [L-1:0]  pv = '0;
  logic [15:0]   pr [L] = '{default: '0};
  int            n_chk = 0, n_fail = 0;
  int            c, ngnt, nrsp;

  div_share_arbiter #(.N_REQ(N), .DIV_LATENCY(L)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .REQ_DIVIDEND(REQ_DIVIDEND), .REQ_DIVISOR(REQ_DIVISOR),
    .GNT(GNT), .RSP_VALID(RSP_VALID), .RSP_REM(RSP_REM), .RSP_DIVZERO(RSP_DIVZERO),
    .DIV_DIVIDEND(DIV_DIVIDEND), .DIV_DIVISOR(DIV_DIVISOR), .DIV_TVALID(DIV_TVALID),
    .DIV_TREADY(DIV_TREADY), .DIV_REM(DIV_REM), .DIV_DOUT_TVALID(DIV_DOUT_TVALID),
    .ERR_UNDERFLOW(ERR_UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  // divider model: fixed L-cycle pipeline, not affected by the arbiter reset
  always @(posedge CLK) begin
    pv    <= {pv[L-2:0], DIV_TVALID & DIV_TREADY};
    pr[0] <= (DIV_DIVISOR == 16'h0) ? 16'h0 : 16'(DIV_DIVIDEND % {48'h0, DIV_DIVISOR});
    for (int i = L - 1; i > 0; i--) pr[i] <= pr[i-1];
  end
  assign DIV_DOUT_TVALID = pv[L-1] | inj;
  assign DIV_REM         = pr[L-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_rsp(input int budget, output int cyc);
    cyc = 0;
    do begin
      tick;
      cyc++;
    end while (RSP_VALID == '0 && cyc < budget);
  endtask

  task automatic set_op(input int i, input logic [63:0] d, input logic [15:0] s);
    REQ_DIVIDEND[64*i +: 64] = d;
    REQ_DIVISOR[16*i +: 16]  = s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) tick;
    check("rst_gnt", GNT, 0);
    check("rst_rsp", RSP_VALID, 0);
    check("rst_tvalid", DIV_TVALID, 0);
    check("rst_err", ERR_UNDERFLOW, 0);
    check("rst_rem", RSP_REM, 0);
    check("rst_dvd", DIV_DIVIDEND, 0);
    RST = 1'b0;
    repeat (L + 2) tick;
    check("drain_idle_gnt", GNT, 0);

    // all three requesting: grants 0,1,2 on alternate cycles
    set_op(0, 64'd1000, 16'd7);
    set_op(1, 64'd12345, 16'd100);
    set_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 16'hFFFE);
    REQ = 3'b111;
    tick;
    check("rr_g0", GNT, 3'b001);
    check("rr_tv", DIV_TVALID, 1);
    check("rr_dvd0", DIV_DIVIDEND, 64'd1000);
    check("rr_dvs0", DIV_DIVISOR, 16'd7);
    tick; check("rr_gap0", GNT, 0);
    tick; check("rr_g1", GNT, 3'b010);
    tick; check("rr_gap1", GNT, 0);
    tick;
    check("rr_g2", GNT, 3'b100);
    check("rr_dvd2", DIV_DIVIDEND, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rr_dvs2", DIV_DIVISOR, 16'hFFFE);
    tick; check("rr_allbusy", GNT, 0);
    wait_rsp(100, c);
    check("rr_rsp0", RSP_VALID, 3'b001);
    check("rr_rem0", RSP_REM[15:0], 16'd6);
    check("rr_dz0", RSP_DIVZERO, 0);
    tick;
    check("rr_regrant0", GNT, 3'b001);
    check("rr_norsp", RSP_VALID, 0);
    REQ = 3'b000;
    tick;
    check("rr_rsp1", RSP_VALID, 3'b010);
    check("rr_rem1", RSP_REM[31:16], 16'd45);
    tick; check("rr_gap_rsp", RSP_VALID, 0);
    tick;
    check("rr_rsp2", RSP_VALID, 3'b100);
    check("rr_rem2", RSP_REM[47:32], 16'd15);
    wait_rsp(100, c);
    check("rr_rsp0b", RSP_VALID, 3'b001);
    check("rr_rem0b", RSP_REM[15:0], 16'd6);
    check("rr_rem1_held", RSP_REM[31:16], 16'd45);

    // single requester latency
    REQ = 3'b001;
    tick;
    check("s_gnt", GNT, 3'b001);
    REQ = 3'b000;
    wait_rsp(100, c);
    check("s_lat", c, 69);
    check("s_rsp", RSP_VALID, 3'b001);
    check("s_rem", RSP_REM[15:0], 16'd6);

    // divider stall: operands held, no other grant
    DIV_TREADY = 1'b0;
    set_op(1, 64'd77, 16'd10);
    set_op(0, 64'd500, 16'd9);
    REQ = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick;
      check("st_gnt", GNT, (i == 0) ? 3'b010 : 3'b000);
      check("st_tv", DIV_TVALID, 1);
      check("st_dvd", DIV_DIVIDEND, 64'd77);
      check("st_dvs", DIV_DIVISOR, 16'd10);
      if (i == 0) REQ = 3'b001;
    end
    DIV_TREADY = 1'b1;
    tick;
    check("st_rel_tv", DIV_TVALID, 0);
    check("st_rel_gnt", GNT, 0);
    tick;
    check("st_g0", GNT, 3'b001);
    check("st_dvd0", DIV_DIVIDEND, 64'd500);
    REQ = 3'b000;
    wait_rsp(100, c);
    check("st_rsp1", RSP_VALID, 3'b010);
    check("st_rem1", RSP_REM[31:16], 16'd7);
    tick; check("st_gap", RSP_VALID, 0);
    tick;
    check("st_rsp0", RSP_VALID, 3'b001);
    check("st_rem0", RSP_REM[15:0], 16'd5);

    // zero divisor on requester 1, request held across its own response
    set_op(1, 64'd123, 16'd0);
    REQ = 3'b010;
    tick;
    check("z_gnt", GNT, 3'b010);
    check("z_tv", DIV_TVALID, 0);
    check("z_norsp", RSP_VALID, 0);
    tick;
    check("z_rsp", RSP_VALID, 3'b010);
    check("z_dz", RSP_DIVZERO, 3'b010);
    check("z_rem", RSP_REM[31:16], 16'd0);
    check("z_busy_gnt", GNT, 0);
    tick;
    check("z_regrant", GNT, 3'b010);
    check("z_tv2", DIV_TVALID, 0);
    REQ = 3'b000;
    tick;
    check("z_rsp2", RSP_VALID, 3'b010);

    // reset with two divisions in flight
    set_op(0, 64'd1000, 16'd7);
    set_op(1, 64'd12345, 16'd100);
    REQ = 3'b011;
    tick; check("rm_g0", GNT, 3'b001);
    tick;
    tick; check("rm_g1", GNT, 3'b010);
    REQ = 3'b000;
    repeat (3) tick;
    RST = 1'b1;
    #1;
    check("rm_gnt", GNT, 0);
    check("rm_tv", DIV_TVALID, 0);
    check("rm_rem", RSP_REM, 0);
    check("rm_dvd", DIV_DIVIDEND, 0);
    repeat (2) tick;
    RST = 1'b0;
    set_op(2, 64'd5, 16'd0);
    REQ = 3'b100;
    ngnt = 0;
    nrsp = 0;
    for (int i = 0; i < 66; i++) begin
      tick;
      if (GNT != '0) ngnt++;
      if (RSP_VALID != '0) nrsp++;
    end
    check("rm_drain_gnt", ngnt, 0);
    check("rm_drain_rsp", nrsp, 0);
    check("rm_err", ERR_UNDERFLOW, 0);
    c = 0;
    do begin
      tick;
      c++;
    end while (GNT == '0 && c < 10);
    check("rm_post_gnt", GNT, 3'b100);
    REQ = 3'b000;
    tick;
    check("rm_post_rsp", RSP_VALID, 3'b100);
    check("rm_post_dz", RSP_DIVZERO, 3'b100);

    // stray divider output with empty tag FIFO
    repeat (3) tick;
    check("uf_pre", ERR_UNDERFLOW, 0);
    inj = 1'b1;
    tick;
    inj = 1'b0;
    check("uf_err", ERR_UNDERFLOW, 1);
    check("uf_norsp", RSP_VALID, 0);
    nrsp = 0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (RSP_VALID != '0) nrsp++;
    end
    check("uf_sticky", ERR_UNDERFLOW, 1);
    check("uf_norsp_after", nrsp, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
